// File: rtl/gate_tt_pkg.sv
// gate_tt_pkg
//   Shared types and helpers for the gate truth-table checker.
//   - tt_state_t : checker FSM states
//   - SETTLE_W   : width of the settle down-counter (SETTLE legal range 1..15)
//   - n_vec()    : number of input vectors for a gate with n inputs
package gate_tt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } tt_state_t;

    localparam int SETTLE_W = 4;

    function automatic int n_vec(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/gate_tt_checker_settle_timer.sv
// tt_settle_timer
//   Down-counter that times how long each vector is held before sampling.
//   Ports:
//     i_clk       clock, all state on rising edge
//     i_rst       synchronous active-high reset
//     i_load      load i_load_val (takes priority over decrement)
//     i_load_val  value loaded on i_load
//     i_dec       decrement by one, stopping at zero
//     o_expired   count has reached zero
module tt_settle_timer
    import gate_tt_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_load,
    input  logic [SETTLE_W-1:0] i_load_val,
    input  logic                i_dec,
    output logic                o_expired
);

    logic [SETTLE_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - SETTLE_W'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/gate_tt_checker.sv
// gate_tt_checker
//   Sweeps every input vector of a combinational gate, holds each for SETTLE
//   cycles, samples the gate output and compares it with TRUTH[vector].
//   Counts mismatches (saturating) and reports a pass/fail verdict.
//   Ports:
//     i_clk        clock
//     i_rst        synchronous active-high reset
//     i_start      sweep request, honoured only in IDLE
//     i_dut_out    output of the gate under test
//     o_dut_in     vector driven to the gate (bit0 = a, bit1 = b)
//     o_busy       sweep in progress (DRIVE/SAMPLE)
//     o_done       one-cycle pulse at end of sweep
//     o_pass       last sweep had zero mismatches; held until next start
//     o_err_count  mismatches in current/last sweep, saturating
//   Optional feature, macro FIRST_FAIL_CAPTURE_EN:
//     o_first_fail_valid / o_first_fail_vec capture the first failing vector.
//
//   state  | meaning
//   IDLE   | waiting for start
//   DRIVE  | vector applied, settle timer running
//   SAMPLE | compare gate output with truth table, advance vector
//   DONE   | one-cycle done pulse, verdict valid
module gate_tt_checker
    import gate_tt_pkg::*;
#(
    parameter int                      N_IN   = 2,
    parameter logic [n_vec(N_IN)-1:0]  TRUTH  = 4'b1000,
    parameter int                      SETTLE = 2,
    parameter int                      CNT_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_dut_out,
    output logic [N_IN-1:0]   o_dut_in,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
`ifdef FIRST_FAIL_CAPTURE_EN
    output logic              o_first_fail_valid,
    output logic [N_IN-1:0]   o_first_fail_vec,
`endif
    output logic [CNT_W-1:0]  o_err_count
);

    localparam logic [N_IN-1:0]     LAST_VEC    = '1;
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);

    tt_state_t        r_state;
    logic [N_IN-1:0]  r_vec;
    logic [CNT_W-1:0] r_err;
    logic             r_pass;

    logic             w_accept;
    logic             w_mismatch;
    logic [CNT_W-1:0] w_err_next;
    logic             w_last;
    logic             w_timer_load;
    logic             w_expired;

    assign w_accept   = (r_state == IDLE) && i_start;
    assign w_last     = (r_vec == LAST_VEC);
    assign w_mismatch = (i_dut_out != TRUTH[r_vec]);
    assign w_err_next = (w_mismatch && (r_err != '1)) ? r_err + CNT_W'(1) : r_err;

    // Reload on every entry into DRIVE so each vector gets a full settle window.
    assign w_timer_load = w_accept || ((r_state == SAMPLE) && !w_last);

    tt_settle_timer u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_timer_load),
        .i_load_val (SETTLE_LOAD),
        .i_dec      (r_state == DRIVE),
        .o_expired  (w_expired)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_vec   <= '0;
            r_err   <= '0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state <= DRIVE;
                        r_vec   <= '0;
                        r_err   <= '0;
                        r_pass  <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (w_expired) r_state <= SAMPLE;
                end
                SAMPLE: begin
                    r_err <= w_err_next;
                    if (w_last) begin
                        r_state <= DONE;
                        // Use the post-sample count so the final vector's result
                        // is already reflected while o_done is high.
                        r_pass  <= (w_err_next == '0);
                    end else begin
                        r_vec   <= r_vec + N_IN'(1);
                        r_state <= DRIVE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef FIRST_FAIL_CAPTURE_EN
    logic            r_ff_valid;
    logic [N_IN-1:0] r_ff_vec;

    always_ff @(posedge i_clk) begin
        if (i_rst || w_accept) begin
            r_ff_valid <= 1'b0;
            r_ff_vec   <= '0;
        end else if ((r_state == SAMPLE) && w_mismatch && !r_ff_valid) begin
            r_ff_valid <= 1'b1;
            r_ff_vec   <= r_vec;
        end
    end

    assign o_first_fail_valid = r_ff_valid;
    assign o_first_fail_vec   = r_ff_vec;
`else
    // No first-fail capture in this build.
`endif

    assign o_dut_in    = r_vec;
    assign o_busy      = (r_state == DRIVE) || (r_state == SAMPLE);
    assign o_done      = (r_state == DONE);
    assign o_pass      = r_pass;
    assign o_err_count = r_err;

endmodule
